// File: rtl/uart_pkg.sv
// Shared constants and FSM state types for the serial echo design.
package uart_pkg;

    localparam int unsigned DATA_BITS            = 8;
    localparam int unsigned STOP_BITS            = 1;
    localparam int unsigned DEFAULT_CLKS_PER_BIT = 104;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

endpackage

// File: rtl/echo_if.sv
// Serial pin pair of the echo block; slave is the design side, master the line partner.
interface echo_if;

    logic rx;
    logic tx;

    modport slave  (input  rx, output tx);
    modport master (output rx, input  tx);

endinterface

// File: rtl/baud_tick.sv
// Loadable down-counter; tick marks the last cycle of a loaded interval.
module baud_tick #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             tick
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // A load of N makes tick fire N cycles after the loading cycle.
    assign tick = (count_q == WIDTH'(1));

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/echo.sv
// UART 8N1 loopback: synchronizer, receiver FSM, one-byte holding register, transmitter FSM.
module echo
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic   clk,
    input  logic   rstn,
    echo_if.slave  uart
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam int unsigned BIT_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);

    logic rx_meta_q;
    logic rx_sync_q;

    rx_state_e            rx_state_q, rx_state_d;
    logic [BIT_W-1:0]     rx_bits_q, rx_bits_d;
    logic [DATA_BITS-1:0] rx_shreg_q, rx_shreg_d;
    logic                 rx_load;
    logic [CNT_W-1:0]     rx_load_val;
    logic                 rx_tick;
    logic                 rx_done;

    logic [DATA_BITS-1:0] hold_q, hold_d;
    logic                 full_q, full_d;
    logic                 tx_take;

    tx_state_e            tx_state_q, tx_state_d;
    logic [BIT_W-1:0]     tx_bits_q, tx_bits_d;
    logic [DATA_BITS-1:0] tx_shreg_q, tx_shreg_d;
    logic                 tx_q, tx_d;
    logic                 tx_load;
    logic                 tx_tick;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= uart.rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    baud_tick #(.WIDTH(CNT_W)) u_rx_tick (
        .clk      (clk),
        .rstn     (rstn),
        .load     (rx_load),
        .load_val (rx_load_val),
        .tick     (rx_tick)
    );

    baud_tick #(.WIDTH(CNT_W)) u_tx_tick (
        .clk      (clk),
        .rstn     (rstn),
        .load     (tx_load),
        .load_val (BIT_LOAD),
        .tick     (tx_tick)
    );

    always_comb begin
        rx_state_d  = rx_state_q;
        rx_bits_d   = rx_bits_q;
        rx_shreg_d  = rx_shreg_q;
        rx_load     = 1'b0;
        rx_load_val = BIT_LOAD;
        rx_done     = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (!rx_sync_q) begin
                    rx_state_d  = RX_START;
                    rx_load     = 1'b1;
                    rx_load_val = HALF_LOAD;
                end
            end
            RX_START: begin
                if (rx_tick) begin
                    if (!rx_sync_q) begin
                        rx_state_d = RX_DATA;
                        rx_bits_d  = '0;
                        rx_load    = 1'b1;
                    end else begin
                        rx_state_d = RX_IDLE;
                    end
                end
            end
            RX_DATA: begin
                if (rx_tick) begin
                    rx_shreg_d = {rx_sync_q, rx_shreg_q[DATA_BITS-1:1]};
                    rx_load    = 1'b1;
                    if (rx_bits_q == LAST_BIT) begin
                        rx_state_d = RX_STOP;
                    end else begin
                        rx_bits_d = rx_bits_q + BIT_W'(1);
                    end
                end
            end
            RX_STOP: begin
                // Back to idle at mid-stop so the next start edge is not missed.
                if (rx_tick) begin
                    rx_done    = rx_sync_q;
                    rx_state_d = RX_IDLE;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    assign tx_take = (tx_state_q == TX_IDLE) && full_q;

    // A write coinciding with the transmitter's load is accepted, not an overrun.
    always_comb begin
        hold_d = hold_q;
        full_d = full_q;
        if (tx_take) begin
            full_d = 1'b0;
        end
        if (rx_done && (!full_q || tx_take)) begin
            hold_d = rx_shreg_q;
            full_d = 1'b1;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_bits_d  = tx_bits_q;
        tx_shreg_d = tx_shreg_q;
        tx_d       = tx_q;
        tx_load    = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                if (full_q) begin
                    tx_state_d = TX_START;
                    tx_shreg_d = hold_q;
                    tx_bits_d  = '0;
                    tx_d       = 1'b0;
                    tx_load    = 1'b1;
                end
            end
            TX_START: begin
                if (tx_tick) begin
                    tx_state_d = TX_DATA;
                    tx_d       = tx_shreg_q[0];
                    tx_shreg_d = {1'b0, tx_shreg_q[DATA_BITS-1:1]};
                    tx_load    = 1'b1;
                end
            end
            TX_DATA: begin
                if (tx_tick) begin
                    tx_load = 1'b1;
                    if (tx_bits_q == LAST_BIT) begin
                        tx_state_d = TX_STOP;
                        tx_d       = 1'b1;
                    end else begin
                        tx_d       = tx_shreg_q[0];
                        tx_shreg_d = {1'b0, tx_shreg_q[DATA_BITS-1:1]};
                        tx_bits_d  = tx_bits_q + BIT_W'(1);
                    end
                end
            end
            TX_STOP: begin
                if (tx_tick) begin
                    tx_state_d = TX_IDLE;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_state_q <= RX_IDLE;
            rx_bits_q  <= '0;
            rx_shreg_q <= '0;
            hold_q     <= '0;
            full_q     <= 1'b0;
            tx_state_q <= TX_IDLE;
            tx_bits_q  <= '0;
            tx_shreg_q <= '0;
            tx_q       <= 1'b1;
        end else begin
            rx_state_q <= rx_state_d;
            rx_bits_q  <= rx_bits_d;
            rx_shreg_q <= rx_shreg_d;
            hold_q     <= hold_d;
            full_q     <= full_d;
            tx_state_q <= tx_state_d;
            tx_bits_q  <= tx_bits_d;
            tx_shreg_q <= tx_shreg_d;
            tx_q       <= tx_d;
        end
    end

    assign uart.tx = tx_q;

endmodule

// File: tb/tb_echo.sv
// Self-checking bench for echo: line-level frame driver, tx frame decoder and an expected-byte queue.
module tb_echo;
    import uart_pkg::*;

    localparam int unsigned C          = 4;
    localparam int unsigned FRAME_BITS = 1 + DATA_BITS + STOP_BITS;
    // Sync (2) + stop-bit sample offset + holding write + tx start edge.
    localparam int unsigned LATENCY    = 2 + C / 2 + (DATA_BITS + 1) * C + 2;

    logic clk = 1'b0;
    logic rstn;
    echo_if uart ();

    echo #(.CLKS_PER_BIT(C)) dut (
        .clk  (clk),
        .rstn (rstn),
        .uart (uart)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [7:0]  exp_q[$];

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // tx frame decoder
    logic        mon_active = 1'b0;
    int unsigned mon_t;
    logic [7:0]  mon_byte;
    int unsigned prev_start;
    logic        prev_valid = 1'b0;
    logic        b2b_chk    = 1'b0;
    logic        lat_armed  = 1'b0;
    int unsigned lat_ref;
    int unsigned frames_seen = 0;

    always @(negedge clk) begin : monitor
        int unsigned k, off, exp_b;
        if (!rstn) begin
            mon_active = 1'b0;
            prev_valid = 1'b0;
        end else if (!mon_active) begin
            if (uart.tx === 1'b0) begin
                mon_active = 1'b1;
                mon_t      = 0;
                mon_byte   = '0;
                frames_seen++;
                if (lat_armed) begin
                    check("echo_latency", cyc - lat_ref, LATENCY);
                    lat_armed = 1'b0;
                end
                if (prev_valid) begin
                    check("frame_spacing_min", 32'((cyc - prev_start) >= FRAME_BITS * C), 1);
                    if (b2b_chk)
                        check("b2b_spacing_max", 32'((cyc - prev_start) <= FRAME_BITS * C + 1), 1);
                end
                prev_start = cyc;
                prev_valid = 1'b1;
            end
        end else begin
            mon_t++;
            k   = mon_t / C;
            off = mon_t % C;
            if (off == C / 2 || off == C - 1) begin
                if (k == 0) begin
                    check("start_bit", uart.tx, 0);
                end else if (k == FRAME_BITS - 1) begin
                    check("stop_bit", uart.tx, 1);
                end else if (off == C / 2) begin
                    mon_byte[k-1] = uart.tx;
                end else begin
                    check("data_bit_width", uart.tx, mon_byte[k-1]);
                end
            end
            if (mon_t == FRAME_BITS * C - 1) begin
                exp_b = (exp_q.size() != 0) ? 32'(exp_q.pop_front()) : 32'h100;
                check("echo_byte", mon_byte, exp_b);
                mon_active = 1'b0;
            end
        end
    end

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic expect_echo,
                              input logic arm_latency);
        if (expect_echo) exp_q.push_back(b);
        uart.rx = 1'b0;
        if (arm_latency) begin
            lat_ref   = cyc;
            lat_armed = 1'b1;
        end
        repeat (C) @(posedge clk);
        #1;
        for (int i = 0; i < DATA_BITS; i++) begin
            uart.rx = b[i];
            repeat (C) @(posedge clk);
            #1;
        end
        uart.rx = stop_bit;
        repeat (C) @(posedge clk);
        #1;
        uart.rx = 1'b1;
    endtask

    task automatic idle_bits(input int unsigned n);
        uart.rx = 1'b1;
        repeat (n * C) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 600 && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        idle_bits(2);
        check("drain_pending", exp_q.size(), 0);
    endtask

    logic [7:0] seq[8] = '{8'h31, 8'h31, 8'h0D, 8'h31, 8'h30, 8'h31, 8'h0D, 8'h0D};
    logic [7:0] b2b[3] = '{8'h55, 8'hAA, 8'h0D};

    initial begin
        int unsigned fs;
        int unsigned w;
        logic [7:0]  rb;
        logic        good;

        uart.rx = 1'b1;
        rstn    = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 16; i++) begin
            uart.rx = 1'($urandom);
            @(posedge clk);
            #1;
            check("tx_in_reset", uart.tx, 1);
        end
        uart.rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (i % 6 == 0) check("tx_idle_after_reset", uart.tx, 1);
        end

        send_frame(8'h31, 1'b1, 1'b1, 1'b1);
        idle_bits(14);
        wait_drain();

        foreach (seq[i]) begin
            send_frame(seq[i], 1'b1, 1'b1, 1'b0);
            idle_bits(8);
        end
        wait_drain();

        prev_valid = 1'b0;
        b2b_chk    = 1'b1;
        foreach (b2b[i]) send_frame(b2b[i], 1'b1, 1'b1, 1'b0);
        idle_bits(14);
        wait_drain();
        b2b_chk = 1'b0;

        fs = frames_seen;
        uart.rx = 1'b0;
        @(posedge clk);
        #1;
        idle_bits(15);
        check("glitch_no_echo", frames_seen - fs, 0);

        fs = frames_seen;
        send_frame(8'h41, 1'b0, 1'b0, 1'b0);
        idle_bits(15);
        check("framing_error_no_echo", frames_seen - fs, 0);
        send_frame(8'h35, 1'b1, 1'b1, 1'b0);
        idle_bits(14);
        wait_drain();

        send_frame(8'h31, 1'b1, 1'b0, 1'b0);
        w = 0;
        while (uart.tx !== 1'b0 && w < 100) begin
            @(posedge clk);
            #1;
            w++;
        end
        check("midtx_start_seen", uart.tx, 0);
        repeat (6) @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        check("tx_async_reset", uart.tx, 1);
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        fs = frames_seen;
        for (int i = 0; i < 15 * C; i++) begin
            @(posedge clk);
            #1;
            if (i % 8 == 0) check("tx_quiet_after_abort", uart.tx, 1);
        end
        check("no_frame_after_abort", frames_seen - fs, 0);
        send_frame(8'h30, 1'b1, 1'b1, 1'b0);
        idle_bits(14);
        wait_drain();

        for (int i = 0; i < 12; i++) begin
            rb   = 8'($urandom);
            good = ($urandom_range(0, 5) != 0);
            send_frame(rb, good, good, 1'b0);
            idle_bits(good ? $urandom_range(0, 2) : 1 + $urandom_range(0, 2));
        end
        idle_bits(14);
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no end, expected end of stimulus");
        $fatal(1, "watchdog");
    end

endmodule
